// File: rtl/onewire_bit_engine.sv
// Bit-level 1-Wire bus master: reset/presence, write-bit and read-bit slots at standard speed.
// Slot timing is derived from CLK_FREQ; the bus is open-drain and only ever pulled low.
module onewire_bit_engine #(
    parameter int CLK_FREQ  = 60_000_000,
    parameter int T_RSTL_US = 480,
    parameter int T_PDS_US  = 70,
    parameter int T_RSTH_US = 480,
    parameter int T_LOW0_US = 60,
    parameter int T_LOW1_US = 6,
    parameter int T_RDS_US  = 15,
    parameter int T_SLOT_US = 70
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_reset,
    input  logic start_write_bit,
    input  logic start_read_bit,
    input  logic write_bit_data,
    output logic busy,
    output logic done,
    output logic read_bit_data,
    output logic presence_detected,
    inout  wire  onewire_io
);

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_HIGH,
        WR_LOW,
        WR_HIGH,
        RD_LOW,
        RD_HIGH
    } state_t;

    localparam int CPU = CLK_FREQ / 1_000_000;

    // Terminal counts are "last cycle in state" values. The high phases end two
    // short because the IDLE cycle carrying done is the final cycle of the slot.
    localparam logic [23:0] RSTL_END     = 24'(T_RSTL_US * CPU - 1);
    localparam logic [23:0] PDS_CNT      = 24'(T_PDS_US * CPU);
    localparam logic [23:0] RSTH_END     = 24'(T_RSTH_US * CPU - 2);
    localparam logic [23:0] LOW0_END     = 24'(T_LOW0_US * CPU - 1);
    localparam logic [23:0] LOW1_END     = 24'(T_LOW1_US * CPU - 1);
    localparam logic [23:0] RDS_CNT      = 24'((T_RDS_US - T_LOW1_US) * CPU);
    localparam logic [23:0] HIGH0_END    = 24'((T_SLOT_US - T_LOW0_US) * CPU - 2);
    localparam logic [23:0] HIGH1_END    = 24'((T_SLOT_US - T_LOW1_US) * CPU - 2);

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        drive_low_q, drive_low_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        wbit_q, wbit_d;
    logic        read_bit_q, read_bit_d;
    logic        presence_q, presence_d;
    logic        line_m_q, line_s_q;

    assign onewire_io        = drive_low_q ? 1'b0 : 1'bz;
    assign busy              = busy_q;
    assign done              = done_q;
    assign read_bit_data     = read_bit_q;
    assign presence_detected = presence_q;

    // Two-flop synchronizer; idles at 1 because the bus rests released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_m_q <= 1'b1;
            line_s_q <= 1'b1;
        end else begin
            line_m_q <= onewire_io;
            line_s_q <= line_m_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            drive_low_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wbit_q      <= 1'b0;
            read_bit_q  <= 1'b0;
            presence_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drive_low_q <= drive_low_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wbit_q      <= wbit_d;
            read_bit_q  <= read_bit_d;
            presence_q  <= presence_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 24'd1;
        drive_low_d = drive_low_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        wbit_d      = wbit_q;
        read_bit_d  = read_bit_q;
        presence_d  = presence_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Reset outranks write, write outranks read.
                if (start_reset) begin
                    state_d     = RST_LOW;
                    drive_low_d = 1'b1;
                    busy_d      = 1'b1;
                end else if (start_write_bit) begin
                    state_d     = WR_LOW;
                    drive_low_d = 1'b1;
                    busy_d      = 1'b1;
                    wbit_d      = write_bit_data;
                end else if (start_read_bit) begin
                    state_d     = RD_LOW;
                    drive_low_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end

            RST_LOW: begin
                if (cnt_q == RSTL_END) begin
                    state_d     = RST_HIGH;
                    cnt_d       = '0;
                    drive_low_d = 1'b0;
                end
            end

            RST_HIGH: begin
                if (cnt_q == PDS_CNT) begin
                    presence_d = !line_s_q;
                end
                if (cnt_q == RSTH_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            WR_LOW: begin
                if (cnt_q == (wbit_q ? LOW1_END : LOW0_END)) begin
                    state_d     = WR_HIGH;
                    cnt_d       = '0;
                    drive_low_d = 1'b0;
                end
            end

            WR_HIGH: begin
                if (cnt_q == (wbit_q ? HIGH1_END : HIGH0_END)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            RD_LOW: begin
                if (cnt_q == LOW1_END) begin
                    state_d     = RD_HIGH;
                    cnt_d       = '0;
                    drive_low_d = 1'b0;
                end
            end

            RD_HIGH: begin
                if (cnt_q == RDS_CNT) begin
                    read_bit_d = line_s_q;
                end
                if (cnt_q == HIGH1_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                drive_low_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_onewire_bit_engine.sv
// Directed bench for onewire_bit_engine at 10 MHz (10 cycles/us): reset 4800 low + 4800 high,
// slot 700, write-0 low 600, write-1/read low 60. done cycle minus start-pulse cycle = sequence length.
module tb_onewire_bit_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start_reset = 1'b0;
    logic start_write_bit = 1'b0;
    logic start_read_bit = 1'b0;
    logic write_bit_data = 1'b0;
    logic busy, done, read_bit_data, presence_detected;
    logic slave_low = 1'b0;

    wire onewire_io;
    pullup (onewire_io);
    assign onewire_io = slave_low ? 1'b0 : 1'bz;

    onewire_bit_engine #(
        .CLK_FREQ(10_000_000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_reset      (start_reset),
        .start_write_bit  (start_write_bit),
        .start_read_bit   (start_read_bit),
        .write_bit_data   (write_bit_data),
        .busy             (busy),
        .done             (done),
        .read_bit_data    (read_bit_data),
        .presence_detected(presence_detected),
        .onewire_io       (onewire_io)
    );

    int cyc = 0;
    int win_lo = 0;
    int win_hi = 0;
    int run_len = 0;
    int runs[$];
    int dones[$];
    int checks = 0;
    int passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor (low-run lengths, done cycles) and slave pull-down window.
    always @(negedge clk) begin
        if (onewire_io === 1'b0) begin
            run_len = run_len + 1;
        end else if (run_len > 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
        if (done === 1'b1) dones.push_back(cyc);
        slave_low = (cyc >= win_lo) && (cyc < win_hi);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        runs.delete();
        dones.delete();
    endtask

    task automatic wait_dones(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (dones.size() >= n) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (read_bit_data !== 1'b0) $display("FAIL reset_rbit: got %b expected 0", read_bit_data); else passed++;
        checks++; if (presence_detected !== 1'b0) $display("FAIL reset_pres: got %b expected 0", presence_detected); else passed++;
        checks++; if (onewire_io !== 1'b1) $display("FAIL reset_bus: got %b expected 1", onewire_io); else passed++;
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_presence_slave();
        int s;
        clear_logs();
        step();
        start_reset = 1'b1;
        s = cyc;
        // Release at edge s+4801; slave low 30..150 us after that.
        win_lo = s + 1 + 4800 + 300;
        win_hi = s + 1 + 4800 + 1500;
        step();
        start_reset = 1'b0;
        checks++; if (busy !== 1'b1) $display("FAIL pres_busy_start: got %b expected 1", busy); else passed++;
        checks++; if (onewire_io !== 1'b0) $display("FAIL pres_bus_low: got %b expected 0", onewire_io); else passed++;
        wait_dones(1, 10000);
        checks++;
        if (dones.size() < 1) $display("FAIL pres_done_timeout: got 0 done pulses expected 1");
        else if (dones[0] - s !== 9600) $display("FAIL pres_done_time: got %0d expected 9600", dones[0] - s);
        else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL pres_busy_end: got %b expected 0", busy); else passed++;
        checks++;
        if (runs.size() < 1) $display("FAIL pres_low_len: got no low pulse expected 4800");
        else if (runs[0] !== 4800) $display("FAIL pres_low_len: got %0d expected 4800", runs[0]);
        else passed++;
        checks++; if (presence_detected !== 1'b1) $display("FAIL pres_flag: got %b expected 1", presence_detected); else passed++;
        step();
        checks++; if (done !== 1'b0) $display("FAIL pres_done_width: got %b expected 0", done); else passed++;
    endtask

    task automatic test_back_to_back();
        int s;
        clear_logs();
        step();
        start_write_bit = 1'b1;
        write_bit_data = 1'b0;
        s = cyc;
        step();
        start_write_bit = 1'b0;
        write_bit_data = 1'b1;
        wait_dones(1, 1000);
        // Second start raised in the done cycle itself.
        start_write_bit = 1'b1;
        step();
        start_write_bit = 1'b0;
        write_bit_data = 1'b0;
        wait_dones(2, 1000);
        step();
        checks++;
        if (dones.size() < 2) $display("FAIL b2b_done_count: got %0d expected 2", dones.size());
        else if (dones[0] - s !== 700) $display("FAIL b2b_first_slot: got %0d expected 700", dones[0] - s);
        else passed++;
        checks++;
        if (dones.size() < 2) $display("FAIL b2b_spacing: got %0d pulses expected 2", dones.size());
        else if (dones[1] - dones[0] !== 700) $display("FAIL b2b_spacing: got %0d expected 700", dones[1] - dones[0]);
        else passed++;
        checks++;
        if (runs.size() < 2) $display("FAIL b2b_low_pulses: got %0d pulses expected 2", runs.size());
        else if (runs[0] !== 600 || runs[1] !== 60) $display("FAIL b2b_low_pulses: got %0d,%0d expected 600,60", runs[0], runs[1]);
        else passed++;
    endtask

    task automatic test_read();
        int s;
        clear_logs();
        step();
        start_read_bit = 1'b1;
        s = cyc;
        step();
        start_read_bit = 1'b0;
        wait_dones(1, 1000);
        checks++;
        if (dones.size() < 1) $display("FAIL rd1_done_timeout: got 0 done pulses expected 1");
        else if (dones[0] - s !== 700) $display("FAIL rd1_slot: got %0d expected 700", dones[0] - s);
        else passed++;
        checks++; if (read_bit_data !== 1'b1) $display("FAIL rd1_value: got %b expected 1", read_bit_data); else passed++;

        clear_logs();
        start_write_bit = 1'b1;
        write_bit_data = 1'b0;
        step();
        start_write_bit = 1'b0;
        wait_dones(1, 1000);
        checks++; if (read_bit_data !== 1'b1) $display("FAIL rd1_hold: got %b expected 1", read_bit_data); else passed++;

        clear_logs();
        step();
        start_read_bit = 1'b1;
        s = cyc;
        win_lo = s + 1;
        win_hi = s + 1 + 300;
        step();
        start_read_bit = 1'b0;
        wait_dones(1, 1000);
        checks++; if (read_bit_data !== 1'b0) $display("FAIL rd0_value: got %b expected 0", read_bit_data); else passed++;

        clear_logs();
        start_write_bit = 1'b1;
        write_bit_data = 1'b1;
        step();
        start_write_bit = 1'b0;
        wait_dones(1, 1000);
        checks++; if (read_bit_data !== 1'b0) $display("FAIL rd0_hold: got %b expected 0", read_bit_data); else passed++;
    endtask

    task automatic test_rst_mid();
        int s;
        clear_logs();
        step();
        start_write_bit = 1'b1;
        write_bit_data = 1'b0;
        s = cyc;
        step();
        start_write_bit = 1'b0;
        while (cyc < s + 100) step();
        rst_n = 1'b0;
        step();
        checks++; if (onewire_io !== 1'b1) $display("FAIL mid_bus_released: got %b expected 1", onewire_io); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b expected 0", busy); else passed++;
        checks++; if (presence_detected !== 1'b0) $display("FAIL mid_pres_cleared: got %b expected 0", presence_detected); else passed++;
        step();
        rst_n = 1'b1;
        repeat (800) step();
        checks++; if (dones.size() !== 0) $display("FAIL mid_no_done: got %0d done pulses expected 0", dones.size()); else passed++;
    endtask

    task automatic test_priority_no_slave();
        int s;
        clear_logs();
        step();
        start_reset = 1'b1;
        start_read_bit = 1'b1;
        s = cyc;
        step();
        start_reset = 1'b0;
        start_read_bit = 1'b0;
        repeat (2000) step();
        start_write_bit = 1'b1;
        write_bit_data = 1'b0;
        step();
        start_write_bit = 1'b0;
        wait_dones(1, 10000);
        checks++;
        if (dones.size() < 1) $display("FAIL prio_done_timeout: got 0 done pulses expected 1");
        else if (dones[0] - s !== 9600) $display("FAIL prio_done_time: got %0d expected 9600", dones[0] - s);
        else passed++;
        checks++;
        if (runs.size() < 1) $display("FAIL prio_low_len: got no low pulse expected 4800");
        else if (runs[0] !== 4800) $display("FAIL prio_low_len: got %0d expected 4800", runs[0]);
        else passed++;
        checks++; if (presence_detected !== 1'b0) $display("FAIL noslave_pres: got %b expected 0", presence_detected); else passed++;
        repeat (800) step();
        checks++; if (dones.size() !== 1) $display("FAIL busy_start_ignored: got %0d done pulses expected 1", dones.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_presence_slave();
        test_back_to_back();
        test_read();
        test_rst_mid();
        test_priority_no_slave();
        test_presence_slave();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
